// File: rtl/timer_pkg.sv
// Shared definitions for the machine-timer responder: register byte offsets,
// ctrl bit positions and the bus handshake state encoding.
package timer_pkg;

   localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
   localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
   localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] OFF_CTRL        = 5'h10;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MASK = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } bus_state_t;

endpackage

// File: rtl/data_bus_timer_responder_if.sv
// Core data-bus request/response signals (read_enable/write_enable/wait_req/valid).
interface data_bus_if;
   logic [31:0] address;
   logic        read_enable;
   logic        write_enable;
   logic [31:0] write_data;
   logic [3:0]  byte_enable;
   logic        wait_req;
   logic        valid;
   logic [31:0] read_data;

   modport master (
      output address, read_enable, write_enable, write_data, byte_enable,
      input  wait_req, valid, read_data
   );

   modport slave (
      input  address, read_enable, write_enable, write_data, byte_enable,
      output wait_req, valid, read_data
   );
endinterface

// File: rtl/data_bus_timer_responder_bus_wait_fsm.sv
// Bus handshake sequencer: inserts WAIT_CYCLES wait states, issues a one-cycle
// accept pulse and marks the response cycle of accepted reads.
module bus_wait_fsm
   import timer_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic hit,
   input  logic is_read,
   output logic wait_req,
   output logic accept,
   output logic valid
);

   localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   bus_state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wait_req  = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_WAIT: begin
            if (cnt != 4'd0) begin
               wait_req = 1'b1;
               cnt_nxt  = cnt - 4'd1;
            end else begin
               accept    = 1'b1;
               state_nxt = is_read ? ST_RESP : ST_IDLE;
            end
         end
         // The response cycle doubles as an idle cycle so reads can stream.
         default: begin
            state_nxt = ST_IDLE;
            if (hit) begin
               if (WAIT_CYCLES == 0) begin
                  accept    = 1'b1;
                  state_nxt = is_read ? ST_RESP : ST_IDLE;
               end else begin
                  wait_req  = 1'b1;
                  cnt_nxt   = WAIT_INIT;
                  state_nxt = ST_WAIT;
               end
            end
         end
      endcase
      // Held requests must not see wait_req while reset is asserted.
      if (reset) begin
         wait_req = 1'b0;
         accept   = 1'b0;
      end
   end

   assign valid = (state == ST_RESP);

endmodule

// File: rtl/data_bus_timer_responder.sv
// Memory-mapped mtime/mtimecmp responder with level timer interrupt.
// Optional macro TIMER_PRESCALE_EN: mtime ticks once per PRESCALE clocks.
module data_bus_timer_responder
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_8000,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned PRESCALE    = 1
) (
   input  logic       clock,
   input  logic       reset,
   data_bus_if.slave  bus,
   output logic       timer_irq
);

   logic        hit, accept, rd_acc, wr_acc, tick, mtime_wr;
   logic [4:0]  offset;
   logic [63:0] mtime, mtimecmp;
   logic [1:0]  ctrl;
   logic [31:0] rd_word;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      return res;
   endfunction

   assign hit    = (bus.read_enable | bus.write_enable) &&
                   (bus.address[31:5] == BASE_ADDR[31:5]);
   assign offset = {bus.address[4:2], 2'b00};
   assign rd_acc = accept & bus.read_enable;
   assign wr_acc = accept & bus.write_enable;
   assign mtime_wr = wr_acc && (offset == OFF_MTIME_LO || offset == OFF_MTIME_HI);

   bus_wait_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
      .clock    (clock),
      .reset    (reset),
      .hit      (hit),
      .is_read  (bus.read_enable),
      .wait_req (bus.wait_req),
      .accept   (accept),
      .valid    (bus.valid)
   );

`ifdef TIMER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   logic [PW-1:0] pre_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pre_cnt <= '0;
      else if (!ctrl[CTRL_EN] || mtime_wr || pre_cnt == PRE_LAST)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

   assign tick = (pre_cnt == PRE_LAST);
`else
   assign tick = 1'b1;
`endif

   // A software write to either half wins over the tick of that cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         mtime <= 64'd0;
      else if (wr_acc && offset == OFF_MTIME_LO)
         mtime[31:0] <= merge_bytes(mtime[31:0], bus.write_data, bus.byte_enable);
      else if (wr_acc && offset == OFF_MTIME_HI)
         mtime[63:32] <= merge_bytes(mtime[63:32], bus.write_data, bus.byte_enable);
      else if (ctrl[CTRL_EN] && tick)
         mtime <= mtime + 64'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mtimecmp <= '1;
         ctrl     <= 2'b01;
      end else if (wr_acc) begin
         case (offset)
            OFF_MTIMECMP_LO: mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], bus.write_data, bus.byte_enable);
            OFF_MTIMECMP_HI: mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus.write_data, bus.byte_enable);
            OFF_CTRL:        if (bus.byte_enable[0]) ctrl <= bus.write_data[1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_word = 32'd0;
      case (offset)
         OFF_MTIME_LO:    rd_word = mtime[31:0];
         OFF_MTIME_HI:    rd_word = mtime[63:32];
         OFF_MTIMECMP_LO: rd_word = mtimecmp[31:0];
         OFF_MTIMECMP_HI: rd_word = mtimecmp[63:32];
         OFF_CTRL:        rd_word = {30'd0, ctrl};
         default:         rd_word = 32'd0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.read_data <= 32'd0;
         timer_irq     <= 1'b0;
      end else begin
         if (rd_acc)
            bus.read_data <= rd_word;
         timer_irq <= !ctrl[CTRL_MASK] && (mtime >= mtimecmp);
      end
   end

endmodule
